program_loader: RTL and testbench

Boot-time writer for the instruction memory; the single-cycle core only ever reads it.
- Receives a byte stream (header, payload, checksum) over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and writes them to consecutive word addresses in instruction memory.
- Holds the core (PC update and register/data-memory writes) frozen until a complete, checksum-valid image is loaded.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 51 +++++
 rtl/program_loader.sv | 120 ++++++++++++
 tb/tb_program_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic is_rx_state(input state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register; pulses word_valid the cycle after a word completes.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam int BW     = $clog2(BYTES_PER_WORD);
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  logic [BW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  assign last_byte  = (cnt_q == BW'(BYTES_PER_WORD - 1));
  assign word_valid = valid_q;
  assign word_data  = word_q;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (byte_en) begin
      cnt_d   = cnt_q + BW'(1);
      word_d  = {word_q[WORD_W-9:0], byte_in};
      valid_d = last_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory and
// holds the core frozen until a complete, checksum-valid image has been loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_e                     state_q, state_d;
  logic [8*(HDR_BYTES-1)-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]           words_left_q, words_left_d;
  logic [7:0]                 xor_q, xor_d;
  logic [31:0]                wr_addr_q, wr_addr_d;
  logic                       byte_ready_q, done_q, error_q, cpu_hold_q;

  logic             accept;
  logic             asm_en, asm_clr, asm_last, asm_valid;
  logic [31:0]      asm_word;
  logic [CNT_W-1:0] count_w;

  assign accept = byte_valid && byte_ready_q;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .byte_en    (asm_en),
    .byte_in    (byte_in),
    .last_byte  (asm_last),
    .word_valid (asm_valid),
    .word_data  (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_hi_d     = cnt_hi_q;
    words_left_d = words_left_q;
    xor_d        = xor_q;
    asm_en       = 1'b0;
    asm_clr      = 1'b0;
    count_w      = CNT_W'({cnt_hi_q, byte_in});
    // The address advances on the strobe itself, so it always names the word being written.
    wr_addr_d    = asm_valid ? wr_addr_q + 32'd4 : wr_addr_q;

    if (accept) begin
      case (state_q)
        S_LEN_HI: begin
          cnt_hi_d = byte_in;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          xor_d        = '0;
          asm_clr      = 1'b1;
          words_left_d = count_w;
          if (32'(count_w) > 32'(MAX_WORDS)) state_d = S_ERR;
          else if (count_w == '0)            state_d = S_CSUM;
          else                               state_d = S_DATA;
        end
        S_DATA: begin
          asm_en = 1'b1;
          xor_d  = xor_q ^ byte_in;
          if (asm_last) begin
            words_left_d = words_left_q - CNT_W'(1);
            if (words_left_q == CNT_W'(1)) state_d = S_CSUM;
          end
        end
        S_CSUM: state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LEN_HI;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      xor_q        <= '0;
      wr_addr_q    <= BASE_ADDR;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      words_left_q <= words_left_d;
      xor_q        <= xor_d;
      wr_addr_q    <= wr_addr_d;
      // Status outputs are registered from the next state so they change with it.
      byte_ready_q <= is_rx_state(state_d);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERR);
      cpu_hold_q   <= (state_d != S_DONE);
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = asm_valid;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = asm_word;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus
// and checked by an independent monitor whenever wr_en is seen.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got addr 0x%08h data 0x%08h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("send_timeout", 32'(byte_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic send_all(input int gap);
    foreach (stim[i]) begin
      if (i != 0) repeat (gap) @(posedge clk);
      send(stim[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'h0);
    chk({tag, "_wr_data"}, wr_data, 32'h0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_after_release"}, 32'(byte_ready), 32'd1);
  endtask

  task automatic check_final(input string tag, input logic exp_done);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_sticky"}, {30'd0, done, error}, exp_done ? 32'd2 : 32'd1);
  endtask

  task automatic push_nominal_writes();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h0109_5020});
  endtask

  initial begin
    // Nominal load, back-to-back bytes
    do_reset("rst0");
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    push_nominal_writes();
    send(stim[0]);
    send(stim[1]);
    chk("nom_hold_during_load", 32'(cpu_hold), 32'd1);
    for (int i = 2; i < stim.size(); i++) send(stim[i]);
    check_final("nom", 1'b1);

    // Bad checksum: writes still land, then error
    do_reset("rst1");
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h54};
    push_nominal_writes();
    send_all(0);
    check_final("badcs", 1'b0);

    // Oversized header count (257 words)
    do_reset("rst2");
    stim = '{8'h01, 8'h01};
    send_all(0);
    check_final("size", 1'b0);

    // Empty image, good and bad checksum
    do_reset("rst3");
    stim = '{8'h00, 8'h00, 8'h00};
    send_all(0);
    check_final("empty_ok", 1'b1);
    do_reset("rst4");
    stim = '{8'h00, 8'h00, 8'h01};
    send_all(0);
    check_final("empty_bad", 1'b0);

    // Gapped valid: three idle cycles between bytes
    do_reset("rst5");
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    push_nominal_writes();
    send_all(3);
    check_final("gap", 1'b1);

    // Reset right after the 6th byte drops the in-flight write; reload from scratch
    do_reset("rst6");
    for (int i = 0; i < 6; i++) send(stim[i]);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after_release", 32'(byte_ready), 32'd1);
    push_nominal_writes();
    send_all(0);
    check_final("reload", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
